// File: rtl/count_down_sync.sv
// Free-running synchronous binary down-counter built from T flip-flop cells
// and a ripple borrow chain of 2-input ANDs; asynchronous active-low clear.

module count_down_sync_tff (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= 1'b0;
        else
            q <= q ^ t;
    end

endmodule

module count_down_sync #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] q
);

    // b[i] is high when every bit below i is zero, i.e. a borrow reaches bit i
    logic [WIDTH-1:0] b;

    assign b[0] = 1'b1;

    genvar i;
    generate
        for (i = 1; i < WIDTH; i++) begin : g_borrow
            assign b[i] = b[i-1] & ~q[i-1];
        end

        for (i = 0; i < WIDTH; i++) begin : g_bit
            count_down_sync_tff u_tff (
                .clk   (clk),
                .reset (reset),
                .t     (b[i]),
                .q     (q[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_count_down_sync.sv
// Scoreboard bench for count_down_sync: stimulus queues expected counts,
// a monitor process pops and compares against the 4-bit and 8-bit builds.

module tb_count_down_sync;

    typedef struct {
        string      name;
        int         sel;
        logic [7:0] exp;
    } sb_entry_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       reset8;
    logic [3:0] q4;
    logic [7:0] q8;

    sb_entry_t  sb[$];
    event       chk_ev;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    count_down_sync #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .q     (q4)
    );

    count_down_sync #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset8),
        .q     (q8)
    );

    // monitor: drains every queued expectation against the live DUT outputs
    initial begin
        sb_entry_t  e;
        logic [7:0] act;
        forever begin
            @(chk_ev);
            while (sb.size() > 0) begin
                e   = sb.pop_front();
                act = (e.sel == 0) ? {4'h0, q4} : q8;
                total++;
                if (act !== e.exp) begin
                    bad++;
                    $display("FAIL %s @%0t: got %h expected %h", e.name, $time, act, e.exp);
                end
            end
        end
    end

    task automatic expect4(input string n, input logic [3:0] v);
        sb_entry_t e;
        e.name = n;
        e.sel  = 0;
        e.exp  = {4'h0, v};
        sb.push_back(e);
        -> chk_ev;
    endtask

    task automatic expect8(input string n, input logic [7:0] v);
        sb_entry_t e;
        e.name = n;
        e.sel  = 1;
        e.exp  = v;
        sb.push_back(e);
        -> chk_ev;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] m4;
    logic [7:0] m8;
    logic [3:0] hand_first [4] = '{4'hF, 4'hE, 4'hD, 4'hC};
    logic [3:0] hand_after [5] = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB};

    initial begin
        reset  = 1'b1;
        reset8 = 1'b1;
        #1;
        reset  = 1'b0;
        reset8 = 1'b0;
        #1;
        expect4("por_before_edge", 4'h0);
        expect8("por8_before_edge", 8'h00);
        tick();
        expect4("por_edge_ignored", 4'h0);

        // release between edges
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        expect4("release_no_edge", 4'h0);

        m4 = 4'h0;
        for (int i = 0; i < 16; i++) begin
            tick();
            m4 = m4 - 4'h1;
            expect4($sformatf("cycle_edge%0d", i + 1), m4);
            if (i < 4)
                expect4($sformatf("wrap_hand%0d", i + 1), hand_first[i]);
        end
        expect4("full_cycle_back_to_zero", 4'h0);

        for (int i = 0; i < 12; i++) begin
            tick();
            m4 = m4 - 4'h1;
            expect4($sformatf("recount_edge%0d", i + 1), m4);
        end
        expect4("before_mid_reset", 4'h4);

        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        expect4("async_clear_no_edge", 4'h0);
        tick();
        expect4("held_edge_ignored", 4'h0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        expect4("rerelease_no_edge", 4'h0);

        for (int i = 0; i < 5; i++) begin
            tick();
            expect4($sformatf("after_rereset%0d", i + 1), hand_after[i]);
        end

        expect8("held8_long", 8'h00);
        @(negedge clk);
        #2;
        reset8 = 1'b1;
        tick();
        expect8("w8_first_edge", 8'hFF);
        m8 = 8'hFF;
        for (int i = 1; i < 256; i++) begin
            tick();
            m8 = m8 - 8'h01;
            expect8($sformatf("w8_edge%0d", i + 1), m8);
        end
        expect8("w8_256_edges_zero", 8'h00);

        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
